// File: rtl/pe_rs_v2_if.sv
// Stream and control bundle between the PE array fabric and one pe_rs_v2.
// The master side is the GLB/NoC (or a testbench); the slave side is the PE.
interface pe_rs_v2_if #(
    parameter int DATA_W = 32,
    parameter int PSUM_W = 32
);
    logic              PE_en;
    logic [14:0]       i_config;
    logic [DATA_W-1:0] ifmap;
    logic [DATA_W-1:0] filter;
    logic [PSUM_W-1:0] ipsum;
    logic              ifmap_valid;
    logic              filter_valid;
    logic              ipsum_valid;
    logic              ifmap_ready;
    logic              filter_ready;
    logic              ipsum_ready;
    logic [PSUM_W-1:0] opsum;
    logic              opsum_valid;
    logic              opsum_ready;
    logic              done;
    logic              cfg_err;

    modport master (
        output PE_en, i_config, ifmap, filter, ipsum,
        output ifmap_valid, filter_valid, ipsum_valid, opsum_ready,
        input  ifmap_ready, filter_ready, ipsum_ready,
        input  opsum, opsum_valid, done, cfg_err
    );

    modport slave (
        input  PE_en, i_config, ifmap, filter, ipsum,
        input  ifmap_valid, filter_valid, ipsum_valid, opsum_ready,
        output ifmap_ready, filter_ready, ipsum_ready,
        output opsum, opsum_valid, done, cfg_err
    );
endinterface

// File: rtl/pe_rs_v2.sv
// Row-stationary processing element: keeps a filter row resident, slides an
// ifmap window across it one output column at a time and accumulates p (or q
// in depthwise mode) partial sums per column with one MAC per cycle.
module pe_rs_v2 #(
    parameter int ELEM_W       = 8,
    parameter int LANES        = 4,
    parameter int PSUM_W       = 32,
    parameter int IFMAP_DEPTH  = 12,
    parameter int FILTER_DEPTH = 48,
    parameter int PSUM_DEPTH   = 4,
    parameter int IFMAP_ZP     = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    pe_rs_v2_if.slave   bus
);
    localparam int FI_W = (FILTER_DEPTH > 1) ? $clog2(FILTER_DEPTH) : 1;
    localparam int II_W = (IFMAP_DEPTH > 1) ? $clog2(IFMAP_DEPTH) : 1;
    localparam int PI_W = (PSUM_DEPTH > 1) ? $clog2(PSUM_DEPTH) : 1;
    localparam logic [7:0] IFMAP_DEPTH_L  = 8'(IFMAP_DEPTH);
    localparam logic [7:0] FILTER_DEPTH_L = 8'(FILTER_DEPTH);
    localparam logic [7:0] PSUM_DEPTH_L   = 8'(PSUM_DEPTH);
    localparam logic [7:0] LANES_L        = 8'(LANES);
    localparam logic [ELEM_W-1:0] ZP      = ELEM_W'(IFMAP_ZP);

    typedef enum logic [2:0] {IDLE, LOAD_FILTER, LOAD_IFMAP, LOAD_IPSUM, MAC, DRAIN} state_t;

    // Raw config fields plus the sizes derived from them, kept together so the
    // legality check and the datapath read the same numbers.
    typedef struct packed {
        logic [2:0] q;
        logic [2:0] p;
        logic [2:0] rs;
        logic [4:0] f;
        logic       dw;
        logic       s2;
        logic       relu;
        logic [7:0] ne;     // window size q*rs
        logic [7:0] nf;     // filter words, also the MAC cycle count
        logic [2:0] np;     // psums per column
        logic [7:0] shift;  // ifmap entries retired between columns
    } cfg_t;

    function automatic cfg_t derive(input logic [14:0] raw);
        cfg_t c;
        c.q     = {1'b0, raw[1:0]} + 3'd1;
        c.f     = raw[6:2];
        c.p     = {1'b0, raw[8:7]} + 3'd1;
        c.rs    = {1'b0, raw[11:10]} + 3'd1;
        c.dw    = raw[12];
        c.s2    = raw[13];
        c.relu  = raw[14];
        c.ne    = 8'(c.q) * 8'(c.rs);
        c.nf    = c.dw ? c.ne : 8'(c.p) * c.ne;
        c.np    = c.dw ? c.q : c.p;
        c.shift = c.s2 ? {4'd0, c.q, 1'b0} : 8'(c.q);
        return c;
    endfunction

    function automatic logic cfg_legal(input cfg_t c);
        return (c.ne <= IFMAP_DEPTH_L) && (c.nf <= FILTER_DEPTH_L) &&
               (8'(c.np) <= PSUM_DEPTH_L) && (8'(c.q) <= LANES_L) &&
               (c.shift <= c.ne);
    endfunction

    state_t state_q, state_n;
    cfg_t   cfg_q;
    cfg_t   new_cfg;
    logic   new_ok;

    logic signed [ELEM_W-1:0] filter_spad [FILTER_DEPTH];
    logic signed [ELEM_W-1:0] ifmap_spad  [IFMAP_DEPTH];
    logic        [PSUM_W-1:0] psum_spad   [PSUM_DEPTH];

    logic [7:0] fptr_q, iptr_q, mcnt_q, jcnt_q;
    logic [2:0] pidx_q, kcnt_q, lcnt_q;
    logic [4:0] col_q;

    logic filter_ready_q, ifmap_ready_q, ipsum_ready_q, opsum_valid_q, done_q, cfg_err_q;
    logic f_xfer, i_xfer, p_xfer, o_xfer;
    logic pidx_last, last_col;

    logic signed [ELEM_W-1:0]   mac_f, mac_i, mac_fg, mac_ig;
    logic signed [2*ELEM_W-1:0] prod;
    logic        [PSUM_W-1:0]   prod_ext;
    logic                       mac_skip;
    logic        [2:0]          mac_pidx;
    logic        [PSUM_W-1:0]   drain_val;

    assign new_cfg   = derive(bus.i_config);
    assign new_ok    = cfg_legal(new_cfg);
    assign f_xfer    = bus.filter_valid && filter_ready_q;
    assign i_xfer    = bus.ifmap_valid && ifmap_ready_q;
    assign p_xfer    = bus.ipsum_valid && ipsum_ready_q;
    assign o_xfer    = opsum_valid_q && bus.opsum_ready;
    assign pidx_last = (pidx_q == cfg_q.np - 3'd1);
    assign last_col  = (col_q == cfg_q.f);

    // Next-state decode for the load / MAC / drain sequence.
    always_comb begin
        // NOTE: every variable written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_n = state_q;
        case (state_q)
            IDLE:        if (bus.PE_en && new_ok) state_n = LOAD_FILTER;
            LOAD_FILTER: if (f_xfer && (fptr_q + 8'(cfg_q.q) == cfg_q.nf)) state_n = LOAD_IFMAP;
            LOAD_IFMAP:  if (i_xfer && (iptr_q + 8'(cfg_q.q) == cfg_q.ne)) state_n = LOAD_IPSUM;
            LOAD_IPSUM:  if (p_xfer && pidx_last) state_n = MAC;
            MAC:         if (mcnt_q == cfg_q.nf - 8'd1) state_n = DRAIN;
            DRAIN:       if (o_xfer && pidx_last) state_n = last_col ? IDLE : LOAD_IFMAP;
            default:     state_n = IDLE;
        endcase
    end

    // State register and registered handshake/status outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            filter_ready_q <= 1'b0;
            ifmap_ready_q  <= 1'b0;
            ipsum_ready_q  <= 1'b0;
            opsum_valid_q  <= 1'b0;
            done_q         <= 1'b0;
            cfg_err_q      <= 1'b0;
        end else begin
            state_q        <= state_n;
            filter_ready_q <= (state_n == LOAD_FILTER);
            ifmap_ready_q  <= (state_n == LOAD_IFMAP);
            ipsum_ready_q  <= (state_n == LOAD_IPSUM);
            opsum_valid_q  <= (state_n == DRAIN);
            done_q         <= (state_q == DRAIN) && (state_n == IDLE);
            if (state_q == IDLE && bus.PE_en) cfg_err_q <= !new_ok;
        end
    end

    // MAC operand fetch with zero-skip gating of the multiplier inputs.
    always_comb begin
        mac_f    = filter_spad[FI_W'(mcnt_q)];
        mac_i    = ifmap_spad[II_W'(jcnt_q)];
        mac_skip = (mac_f == '0) || (mac_i == '0);
        mac_fg   = mac_skip ? '0 : mac_f;
        mac_ig   = mac_skip ? '0 : mac_i;
        prod     = mac_fg * mac_ig;
        prod_ext = {{(PSUM_W-2*ELEM_W){prod[2*ELEM_W-1]}}, prod};
        mac_pidx = cfg_q.dw ? lcnt_q : kcnt_q;
    end

    // Datapath: config capture, spad writes, MAC accumulation and window slide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q  <= '0;
            fptr_q <= '0;
            iptr_q <= '0;
            mcnt_q <= '0;
            jcnt_q <= '0;
            pidx_q <= '0;
            kcnt_q <= '0;
            lcnt_q <= '0;
            col_q  <= '0;
            // NOTE: the spads are small register files, so they are cleared by
            // the async reset like any other state rather than left as RAM.
            for (int i = 0; i < FILTER_DEPTH; i++) filter_spad[FI_W'(i)] <= '0;
            for (int i = 0; i < IFMAP_DEPTH; i++)  ifmap_spad[II_W'(i)]  <= '0;
            for (int i = 0; i < PSUM_DEPTH; i++)   psum_spad[PI_W'(i)]   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.PE_en && new_ok) begin
                        cfg_q  <= new_cfg;
                        fptr_q <= '0;
                        iptr_q <= '0;
                        pidx_q <= '0;
                        col_q  <= '0;
                    end
                end
                LOAD_FILTER: begin
                    if (f_xfer) begin
                        for (int l = 0; l < LANES; l++)
                            if (l < int'(cfg_q.q) && int'(fptr_q) + l < FILTER_DEPTH)
                                filter_spad[FI_W'(int'(fptr_q) + l)] <= bus.filter[l*ELEM_W +: ELEM_W];
                        fptr_q <= fptr_q + 8'(cfg_q.q);
                    end
                end
                LOAD_IFMAP: begin
                    if (i_xfer) begin
                        for (int l = 0; l < LANES; l++)
                            if (l < int'(cfg_q.q) && int'(iptr_q) + l < IFMAP_DEPTH)
                                ifmap_spad[II_W'(int'(iptr_q) + l)] <= bus.ifmap[l*ELEM_W +: ELEM_W] ^ ZP;
                        iptr_q <= iptr_q + 8'(cfg_q.q);
                    end
                end
                LOAD_IPSUM: begin
                    if (p_xfer) begin
                        psum_spad[PI_W'(pidx_q)] <= bus.ipsum;
                        if (pidx_last) begin
                            pidx_q <= '0;
                            mcnt_q <= '0;
                            jcnt_q <= '0;
                            kcnt_q <= '0;
                            lcnt_q <= '0;
                        end else begin
                            pidx_q <= pidx_q + 3'd1;
                        end
                    end
                end
                MAC: begin
                    if (!mac_skip)
                        psum_spad[PI_W'(mac_pidx)] <= psum_spad[PI_W'(mac_pidx)] + prod_ext;
                    mcnt_q <= mcnt_q + 8'd1;
                    if (jcnt_q == cfg_q.ne - 8'd1) begin
                        jcnt_q <= '0;
                        kcnt_q <= kcnt_q + 3'd1;
                    end else begin
                        jcnt_q <= jcnt_q + 8'd1;
                    end
                    lcnt_q <= (lcnt_q == cfg_q.q - 3'd1) ? 3'd0 : lcnt_q + 3'd1;
                end
                DRAIN: begin
                    if (o_xfer) begin
                        if (pidx_last) begin
                            pidx_q <= '0;
                            if (!last_col) begin
                                col_q  <= col_q + 5'd1;
                                iptr_q <= iptr_q - cfg_q.shift;
                                for (int i = 0; i < IFMAP_DEPTH; i++)
                                    ifmap_spad[II_W'(i)] <= (i + int'(cfg_q.shift) < IFMAP_DEPTH) ?
                                        ifmap_spad[II_W'(i + int'(cfg_q.shift))] : '0;
                            end
                        end else begin
                            pidx_q <= pidx_q + 3'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Drained value with optional ReLU; forced to zero whenever no opsum is offered.
    always_comb begin
        drain_val = psum_spad[PI_W'(pidx_q)];
        if (cfg_q.relu && drain_val[PSUM_W-1]) drain_val = '0;
    end

    assign bus.filter_ready = filter_ready_q;
    assign bus.ifmap_ready  = ifmap_ready_q;
    assign bus.ipsum_ready  = ipsum_ready_q;
    assign bus.opsum_valid  = opsum_valid_q;
    assign bus.opsum        = opsum_valid_q ? drain_val : '0;
    assign bus.done         = done_q;
    assign bus.cfg_err      = cfg_err_q;
endmodule

// File: doc/pe_rs_v2.md
Name: pe_rs_v2

Overview:
Parametrised row-stationary processing element, the next generation of the array PE.
- Holds a filter row in scratchpad, slides an ifmap window over it and accumulates p (or q, in depthwise mode) partial sums per output column.
- Adds parametrised lane/spad sizing, stride-2 windows, optional ReLU on the output, config-legality checking and a done pulse.
- Sits in the PE array behind the GLB/NoC valid-ready streams.

Parameters:
ELEM_W, 8, width of one ifmap/filter element
LANES, 4, elements packed per DATA_W bus beat (DATA_W = ELEM_W*LANES)
PSUM_W, 32, partial-sum width; also the ipsum/opsum width
IFMAP_DEPTH, 12, ifmap spad entries
FILTER_DEPTH, 48, filter spad entries
PSUM_DEPTH, 4, psum spad entries (max p and max q)
IFMAP_ZP, 128, ifmap zero point; the stored element is raw XOR IFMAP_ZP

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
PE_en  in  1  start request; sampled only in IDLE
i_config  in  15  [1:0] q-1, [6:2] F (columns-1), [8:7] p-1, [9] reserved, [11:10] rs-1, [12] depthwise, [13] stride2, [14] relu_en
ifmap  in  DATA_W  packed uint8 ifmap elements, lane 0 = LSBs
filter  in  DATA_W  packed int8 filter elements, lane 0 = LSBs
ipsum  in  PSUM_W  incoming partial sum
ifmap_valid / filter_valid / ipsum_valid  in  1  source valid
ifmap_ready / filter_ready / ipsum_ready  out  1  PE ready
opsum  out  PSUM_W  outgoing partial sum
opsum_valid  out  1  opsum valid
opsum_ready  in  1  sink ready
done  out  1  one-cycle pulse after the final opsum of the last column
cfg_err  out  1  sticky illegal-config flag

Behaviour:
Reset and config
- Reset (async, rst_n=0): state=IDLE; all spads, counters and flags cleared. All outputs 0 (opsum, valids, readies, done, cfg_err).
- Reset mid-operation aborts immediately; no partial output is emitted afterwards.
- Config latches only on IDLE && PE_en.
- Derived values: Ne = q*rs (window size); Nf = depthwise ? Ne : p*q*rs; Np = depthwise ? q : p; columns = F+1; shift = q*(stride2 ? 2 : 1).
- Illegal config: Ne > IFMAP_DEPTH, Nf > FILTER_DEPTH, Np > PSUM_DEPTH, q > LANES, or shift > Ne.
  - On IDLE && PE_en with an illegal config: set cfg_err, stay in IDLE.
  - cfg_err clears on the next legal PE_en.

Handshake
- A transfer happens when valid && ready are both high in the same cycle.
- Each filter/ifmap beat writes lanes 0..q-1 at the spad write pointer, which then advances by q. Lanes >= q are ignored.
- Readies and opsum_valid are registered state decodes: the first ready is asserted 1 cycle after PE_en.

State machine
- IDLE -> LOAD_FILTER on legal PE_en.
- LOAD_FILTER: filter_ready=1. Exit to LOAD_IFMAP when the pointer reaches Nf. The filter is loaded once per run.
- LOAD_IFMAP: ifmap_ready=1; stored element = raw ^ IFMAP_ZP, read as signed.
  - First column loads rs beats.
  - Later columns load shift/q beats (1, or 2 with stride2).
  - Exit when the ifmap pointer reaches Ne.
- LOAD_IPSUM: ipsum_ready=1. Accept Np words into psum[0..Np-1], then go to MAC.
- MAC: exactly one MAC per cycle, fixed cycle count whether or not products are skipped.
  - Normal mode: Nf cycles; psum[k] += filter[k*Ne+j]*ifmap[j] for k=0..p-1, j=0..Ne-1.
  - Depthwise mode: Ne cycles; psum[j mod q] += filter[j]*ifmap[j].
- DRAIN: opsum_valid=1; opsum = psum[idx], or max(psum[idx],0) if relu_en.
  - opsum stays stable while opsum_ready=0.
  - idx advances on each transfer.
  - After transfer Np-1: if the column count == F, go to IDLE and pulse done in the next cycle. Otherwise increment the column count, pop `shift` oldest ifmap entries (remaining entries shift down; vacated entries are zeroed; pointer -= shift), and go to LOAD_IFMAP.

Arithmetic
- Product is int8 x int8 = 16-bit signed, sign-extended to PSUM_W.
- Accumulation is two's-complement wrap-around; no saturation.
- Zero-skip: when the filter element == 0 or the raw ifmap == IFMAP_ZP, the psum write is suppressed (multiplier input gated). The result is identical to the unskipped result.

Test Plan:
- Normal, p=1 q=1 rs=3 F=0: filter beats 1,2,3; ifmap 0x81,0x82,0x83; ipsum 10 -> one opsum=24, then done pulse, state IDLE.
- Stride2, p=1 q=1 rs=3 F=1, filter 1,1,1, ipsum 0 each column:
  - ifmap 0x81..0x83 -> opsum 6.
  - Exactly 2 further ifmap beats (0x84,0x85) -> opsum 12; done after the second opsum.
- Depthwise q=2 rs=2: filter beats {1,2},{3,4}; ifmap {0x81,0x81},{0x82,0x82}; ipsum 0,0 -> opsums 7 then 10.
- Zero-skip/ZP, p=2 q=1 rs=2: filter 0,5,2,0; ifmap 0x80,0x83; ipsum 1,1 -> opsums 16, 1. MAC lasts exactly 4 cycles.
- ReLU + backpressure: result -5 with relu_en=1 and opsum_ready low for 3 cycles -> opsum_valid held, opsum=0 stable; it is accepted on the 4th cycle.
- Illegal and reset:
  - q=4, rs=4 -> cfg_err=1, no ready asserted.
  - A legal run with rst_n pulsed low during MAC -> all outputs 0 immediately; no opsum_valid after release.
